// File: rtl/dmem_arbiter.sv
// Purpose     : shares one single-port data memory between the cpu load/store path and a host master.
// Latency     : gnt in c0; write strobe in c1 and done in c2; read address c1..c(1+RD_LAT), done+rdata in c(2+RD_LAT).
// Backpressure: a requester holds req/addr/wr/wdata until gnt; cpu_stall stays high until the cpu_done cycle.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   cpu_req/wr/addr/wdata           cpu request (level), held stable until cpu_gnt
//   cpu_gnt, cpu_done, cpu_rdata    grant (combinational), 1-cycle completion pulse, held read data
//   cpu_stall                       cpu_req & ~cpu_done
//   host_*                          same as cpu_* for the host/loader/debug master (no stall output)
//   dmem_addr/data_out/wr           memory bus, all zero while idle
//   dmem_data_in                    memory read data, valid RD_LAT cycles after the address is first driven
//   busy                            an access is in flight (state != IDLE)
module dmem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,  // 1..3, the 2-bit cycle counter never wraps
  parameter int FIXED_PRIO = 0   // 0: round-robin on conflict, 1: cpu always wins
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_done,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_data_out,
  output logic          dmem_wr,
  input  logic [DW-1:0] dmem_data_in,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_HOST = 1'b1;
  localparam logic [1:0] LAST_CNT = 2'(RD_LAT);

  state_t     state;
  logic       owner;
  logic       last_owner;
  logic [1:0] cnt;

  logic          can_grant;
  logic          pick_cpu;
  logic          pick_host;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Grants only come out of IDLE, and never while reset is being sampled,
  // so a requester cannot see a gnt for an access that reset will discard.
  assign can_grant = (state == IDLE) && !reset;

  // On conflict the cpu wins if priority is fixed or the host had the last turn.
  assign pick_cpu  = can_grant && cpu_req &&
                     (!host_req || (FIXED_PRIO != 0) || (last_owner == OWN_HOST));
  assign pick_host = can_grant && host_req && !pick_cpu;

  assign cpu_gnt   = pick_cpu;
  assign host_gnt  = pick_host;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign busy      = (state != IDLE);

  assign sel_wr    = pick_host ? host_wr    : cpu_wr;
  assign sel_addr  = pick_host ? host_addr  : cpu_addr;
  assign sel_wdata = pick_host ? host_wdata : cpu_wdata;

  // The dmem_addr / dmem_data_out registers double as the latched request:
  // they are loaded on the grant edge and held for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWN_CPU;
      last_owner    <= OWN_HOST;  // cpu wins the first tie
      cnt           <= 2'd0;
      dmem_addr     <= '0;
      dmem_data_out <= '0;
      dmem_wr       <= 1'b0;
      cpu_done      <= 1'b0;
      host_done     <= 1'b0;
      cpu_rdata     <= '0;
      host_rdata    <= '0;
    end else begin
      cpu_done  <= 1'b0;
      host_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_cpu || pick_host) begin
            owner      <= pick_host;
            last_owner <= pick_host;
            cnt        <= 2'd0;
            dmem_addr  <= sel_addr;
            if (sel_wr) begin
              state         <= WRITE;
              dmem_wr       <= 1'b1;
              dmem_data_out <= sel_wdata;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          state         <= IDLE;
          dmem_wr       <= 1'b0;
          dmem_addr     <= '0;
          dmem_data_out <= '0;
          cpu_done      <= (owner == OWN_CPU);
          host_done     <= (owner == OWN_HOST);
        end
        READ: begin
          // cnt counts cycles since the address was first driven; the
          // memory's data is valid in the cycle where cnt reaches RD_LAT.
          if (cnt == LAST_CNT) begin
            state     <= IDLE;
            dmem_addr <= '0;
            if (owner == OWN_HOST) begin
              host_rdata <= dmem_data_in;
              host_done  <= 1'b1;
            end else begin
              cpu_rdata <= dmem_data_in;
              cpu_done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose     : self-checking bench for dmem_arbiter, three instances with different RD_LAT / FIXED_PRIO.
// Latency     : checks sample 2 time units after each rising edge; inputs change 1 unit after the edge.
// Backpressure: bench requesters hold their request until the expected grant cycle.
module tb_dmem_arbiter;

  localparam int NI = 3;  // inst 0: RD_LAT=1 rr, inst 1: RD_LAT=3 fixed, inst 2: RD_LAT=2 rr

  logic clk = 1'b0;
  logic reset;

  logic        cpu_req   [NI];
  logic        cpu_wr    [NI];
  logic [15:0] cpu_addr  [NI];
  logic [15:0] cpu_wdata [NI];
  logic        cpu_gnt   [NI];
  logic        cpu_done  [NI];
  logic [15:0] cpu_rdata [NI];
  logic        cpu_stall [NI];
  logic        host_req  [NI];
  logic        host_wr   [NI];
  logic [15:0] host_addr [NI];
  logic [15:0] host_wdata[NI];
  logic        host_gnt  [NI];
  logic        host_done [NI];
  logic [15:0] host_rdata[NI];
  logic [15:0] dmem_addr [NI];
  logic [15:0] dmem_dout [NI];
  logic        dmem_wr   [NI];
  logic [15:0] dmem_din  [NI];
  logic        busy      [NI];
  logic [15:0] ovr_addr  [NI];
  logic [15:0] ovr_dat   [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address unless overridden.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 1) ? 3 : ((g == 2) ? 2 : 1);
    int age = 0;

    dmem_arbiter #(
      .AW(16), .DW(16), .RD_LAT(LAT), .FIXED_PRIO((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_wr(cpu_wr[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_gnt(cpu_gnt[g]), .cpu_done(cpu_done[g]), .cpu_rdata(cpu_rdata[g]), .cpu_stall(cpu_stall[g]),
      .host_req(host_req[g]), .host_wr(host_wr[g]), .host_addr(host_addr[g]), .host_wdata(host_wdata[g]),
      .host_gnt(host_gnt[g]), .host_done(host_done[g]), .host_rdata(host_rdata[g]),
      .dmem_addr(dmem_addr[g]), .dmem_data_out(dmem_dout[g]), .dmem_wr(dmem_wr[g]),
      .dmem_data_in(dmem_din[g]), .busy(busy[g])
    );

    // Read data is only valid exactly LAT cycles after the address first appears.
    always @(posedge clk) age <= (busy[g] && !dmem_wr[g]) ? age + 1 : 0;
    assign dmem_din[g] = (age == LAT) ?
                         ((dmem_addr[g] == ovr_addr[g]) ? ovr_dat[g] : mem_fn(dmem_addr[g])) : 16'hDEAD;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NI; i++) begin
      cpu_req[i] = 1'b0;  cpu_wr[i] = 1'b0;  cpu_addr[i] = 16'h0;  cpu_wdata[i] = 16'h0;
      host_req[i] = 1'b0; host_wr[i] = 1'b0; host_addr[i] = 16'h0; host_wdata[i] = 16'h0;
    end
  endtask

  // Returns in the first cycle after the reset edge, with reset already low.
  task automatic do_reset();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
  endtask

  // Random-phase model state (transaction level)
  int          a_act, a_port, a_g, last, win, len;
  logic        a_wr;
  logic [15:0] a_addr, a_wdata;
  logic [15:0] exp_rd[2];
  logic        pend[2];
  logic        e_cd, e_hd, e_wr, e_busy;
  logic [15:0] e_addr, e_dout;

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < NI; i++) begin
      ovr_addr[i] = 16'hFFFF;
      ovr_dat[i]  = 16'h0;
    end
    nxt();
    nxt();
    #1;
    chk1 ("rst_busy",   busy[0],      1'b0);
    chk1 ("rst_gnt",    cpu_gnt[0] | host_gnt[0], 1'b0);
    chk1 ("rst_done",   cpu_done[0] | host_done[0], 1'b0);
    chk1 ("rst_wr",     dmem_wr[0],   1'b0);
    chk16("rst_addr",   dmem_addr[0], 16'h0);
    chk16("rst_dout",   dmem_dout[0], 16'h0);
    chk16("rst_crd",    cpu_rdata[0], 16'h0);
    chk16("rst_hrd",    host_rdata[0], 16'h0);
    reset = 1'b0;

    // cpu write on inst 0
    nxt();
    cpu_req[0] = 1'b1; cpu_wr[0] = 1'b1; cpu_addr[0] = 16'h0040; cpu_wdata[0] = 16'hBEEF;
    #1;
    chk1("wr_c0_gnt", cpu_gnt[0], 1'b1);
    chk1("wr_c0_hgnt", host_gnt[0], 1'b0);
    chk1("wr_c0_busy", busy[0], 1'b0);
    nxt();
    idle_inputs();
    #1;
    chk1 ("wr_c1_wr",   dmem_wr[0],   1'b1);
    chk16("wr_c1_addr", dmem_addr[0], 16'h0040);
    chk16("wr_c1_dout", dmem_dout[0], 16'hBEEF);
    chk1 ("wr_c1_busy", busy[0],      1'b1);
    chk1 ("wr_c1_done", cpu_done[0],  1'b0);
    nxt(); #1;
    chk1 ("wr_c2_done", cpu_done[0],  1'b1);
    chk1 ("wr_c2_wr",   dmem_wr[0],   1'b0);
    chk1 ("wr_c2_busy", busy[0],      1'b0);
    chk16("wr_c2_addr", dmem_addr[0], 16'h0);
    nxt(); #1;
    chk1("wr_c3_done", cpu_done[0], 1'b0);

    // host read on inst 0 (RD_LAT=1)
    ovr_addr[0] = 16'h0100; ovr_dat[0] = 16'h1234;
    nxt();
    host_req[0] = 1'b1; host_wr[0] = 1'b0; host_addr[0] = 16'h0100;
    #1;
    chk1("hrd_c0_gnt", host_gnt[0], 1'b1);
    chk1("hrd_c0_cgnt", cpu_gnt[0], 1'b0);
    nxt();
    idle_inputs();
    #1;
    chk16("hrd_c1_addr", dmem_addr[0], 16'h0100);
    chk1 ("hrd_c1_wr",   dmem_wr[0],   1'b0);
    nxt(); #1;
    chk16("hrd_c2_addr", dmem_addr[0], 16'h0100);
    chk1 ("hrd_c2_done", host_done[0], 1'b0);
    nxt(); #1;
    chk1 ("hrd_c3_done", host_done[0],  1'b1);
    chk16("hrd_c3_rd",   host_rdata[0], 16'h1234);
    chk16("hrd_c3_crd",  cpu_rdata[0],  16'h0);
    chk16("hrd_c3_addr", dmem_addr[0],  16'h0);

    // contention after reset: inst 0 round-robin, inst 1 fixed priority
    nxt();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1'b1;  cpu_wr[i] = 1'b1;  cpu_addr[i] = 16'h0010;  cpu_wdata[i] = 16'h1111;
      host_req[i] = 1'b1; host_wr[i] = 1'b1; host_addr[i] = 16'h0020; host_wdata[i] = 16'h2222;
    end
    for (int n = 0; n < 9; n++) begin
      #1;
      chk1("rr_cgnt",  cpu_gnt[0],   (n % 4) == 0);
      chk1("rr_hgnt",  host_gnt[0],  (n % 4) == 2);
      chk1("rr_cdone", cpu_done[0],  (n % 4) == 2);
      chk1("rr_hdone", host_done[0], ((n % 4) == 0) && (n > 0));
      chk1("rr_busy",  busy[0],      (n % 2) == 1);
      chk1("fp_cgnt",  cpu_gnt[1],   (n % 2) == 0);
      chk1("fp_hgnt",  host_gnt[1],  1'b0);
      chk1("fp_cdone", cpu_done[1],  ((n % 2) == 0) && (n > 0));
      nxt();
    end
    idle_inputs();
    repeat (6) nxt();

    // stall: cpu read on inst 1 (RD_LAT=3), req held through the done cycle
    ovr_addr[1] = 16'h0200; ovr_dat[1] = 16'hC0DE;
    cpu_req[1] = 1'b1; cpu_wr[1] = 1'b0; cpu_addr[1] = 16'h0200;
    for (int n = 0; n < 6; n++) begin
      #1;
      chk1("st_stall", cpu_stall[1], n < 5);
      chk1("st_done",  cpu_done[1],  n == 5);
      chk1("st_gnt",   cpu_gnt[1],   (n == 0) || (n == 5));
      if (n == 5) chk16("st_rdata", cpu_rdata[1], 16'hC0DE);
      nxt();
    end
    idle_inputs();
    repeat (6) nxt();

    // reset in c2 of a RD_LAT=2 read on inst 2, then an immediate host write
    cpu_req[2] = 1'b1; cpu_wr[2] = 1'b0; cpu_addr[2] = 16'h0300;
    #1;
    chk1("mr_c0_gnt", cpu_gnt[2], 1'b1);
    nxt();
    cpu_req[2] = 1'b0;
    nxt();
    reset = 1'b1;
    #1;
    chk1("mr_c2_busy", busy[2], 1'b1);
    nxt();
    reset = 1'b0;
    host_req[2] = 1'b1; host_wr[2] = 1'b1; host_addr[2] = 16'h0310; host_wdata[2] = 16'h7777;
    #1;
    chk1 ("mr_c3_busy", busy[2],      1'b0);
    chk16("mr_c3_addr", dmem_addr[2], 16'h0);
    chk1 ("mr_c3_done", cpu_done[2],  1'b0);
    chk1 ("mr_c3_hgnt", host_gnt[2],  1'b1);
    nxt();
    idle_inputs();
    #1;
    chk1 ("mr_c4_done", cpu_done[2],  1'b0);
    chk1 ("mr_c4_wr",   dmem_wr[2],   1'b1);
    chk16("mr_c4_addr", dmem_addr[2], 16'h0310);
    chk16("mr_c4_dout", dmem_dout[2], 16'h7777);
    nxt(); #1;
    chk1("mr_c5_hdone", host_done[2], 1'b1);
    chk1("mr_c5_cdone", cpu_done[2],  1'b0);
    nxt(); nxt();

    // cpu rdata is untouched by a later host read (inst 0)
    ovr_addr[0] = 16'h0400; ovr_dat[0] = 16'hAAAA;
    cpu_req[0] = 1'b1; cpu_wr[0] = 1'b0; cpu_addr[0] = 16'h0400;
    #1;
    chk1("sr_cgnt", cpu_gnt[0], 1'b1);
    nxt();
    idle_inputs();
    nxt(); nxt(); #1;
    chk1 ("sr_cdone", cpu_done[0],  1'b1);
    chk16("sr_crd1",  cpu_rdata[0], 16'hAAAA);
    ovr_addr[0] = 16'h0500; ovr_dat[0] = 16'h5555;
    host_req[0] = 1'b1; host_wr[0] = 1'b0; host_addr[0] = 16'h0500;
    #1;
    chk1("sr_hgnt", host_gnt[0], 1'b1);
    nxt();
    idle_inputs();
    nxt(); nxt(); #1;
    chk1 ("sr_hdone", host_done[0],  1'b1);
    chk16("sr_hrd",   host_rdata[0], 16'h5555);
    chk16("sr_crd2",  cpu_rdata[0],  16'hAAAA);
    nxt(); nxt(); #1;
    chk16("sr_crd3",  cpu_rdata[0],  16'hAAAA);

    // randomized traffic on inst 0 against a transaction-level model
    ovr_addr[0] = 16'hFFFF;
    nxt();
    do_reset();
    a_act = 0; last = 1; exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    a_port = 0; a_g = 0; a_wr = 1'b0; a_addr = 16'h0; a_wdata = 16'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) == 0)) pend[p] = 1'b1;
        if (!pend[p] || (cyc == 0) || ($urandom_range(0, 0) == 1)) begin
          // idle or freshly raised: fresh operands; a pending one keeps its
          // operands because only the raise path reaches here with pend set
        end
      end
      if (!cpu_req[0] || !pend[0]) begin
        cpu_wr[0] = 1'($urandom_range(0, 1));
        cpu_addr[0] = 16'($urandom_range(0, 16'hFFFE));
        cpu_wdata[0] = 16'($urandom);
      end
      if (!host_req[0] || !pend[1]) begin
        host_wr[0] = 1'($urandom_range(0, 1));
        host_addr[0] = 16'($urandom_range(0, 16'hFFFE));
        host_wdata[0] = 16'($urandom);
      end
      cpu_req[0]  = pend[0];
      host_req[0] = pend[1];
      #1;
      e_cd = 1'b0; e_hd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_addr = 16'h0; e_dout = 16'h0;
      if (a_act != 0) begin
        len = a_wr ? 1 : 2;  // memory cycles: write 1, read RD_LAT+1
        if ((cyc >= a_g + 1) && (cyc <= a_g + len)) begin
          e_busy = 1'b1; e_addr = a_addr; e_wr = a_wr;
          e_dout = a_wr ? a_wdata : 16'h0;
        end
        if (cyc == a_g + len + 1) begin
          if (a_port == 0) e_cd = 1'b1; else e_hd = 1'b1;
          if (!a_wr) exp_rd[a_port] = mem_fn(a_addr);
          a_act = 0;
        end
      end
      win = -1;
      if (a_act == 0) begin
        if (pend[0] && (!pend[1] || (last == 1))) win = 0;
        else if (pend[1]) win = 1;
      end
      chk1 ("rnd_cgnt",  cpu_gnt[0],    win == 0);
      chk1 ("rnd_hgnt",  host_gnt[0],   win == 1);
      chk1 ("rnd_cdone", cpu_done[0],   e_cd);
      chk1 ("rnd_hdone", host_done[0],  e_hd);
      chk16("rnd_crd",   cpu_rdata[0],  exp_rd[0]);
      chk16("rnd_hrd",   host_rdata[0], exp_rd[1]);
      chk1 ("rnd_wr",    dmem_wr[0],    e_wr);
      chk16("rnd_addr",  dmem_addr[0],  e_addr);
      chk16("rnd_dout",  dmem_dout[0],  e_dout);
      chk1 ("rnd_busy",  busy[0],       e_busy);
      chk1 ("rnd_stall", cpu_stall[0],  pend[0] & ~e_cd);
      if (win >= 0) begin
        a_act = 1; a_port = win; a_g = cyc; last = win;
        a_wr    = (win == 0) ? cpu_wr[0]    : host_wr[0];
        a_addr  = (win == 0) ? cpu_addr[0]  : host_addr[0];
        a_wdata = (win == 0) ? cpu_wdata[0] : host_wdata[0];
        pend[win] = 1'b0;
      end
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor load/store path (cpu port) and a host/loader/debug master (host port).
- Sequences each access: captures the request, drives the dmem bus for the required cycles, samples read data, and returns a done pulse.
- Exports cpu_stall so the stage FSM freezes the pipeline while a cpu access is pending.
- Sits between the processor core / host bridge and the dmem macro.

Parameters:
AW, 16, address width
DW, 16, data width
RD_LAT, 1, memory read latency in cycles (legal 1..3); read data is valid RD_LAT cycles after the address is first driven
FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = cpu always wins

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  cpu access request (level)
cpu_wr  in  1  1 = write, 0 = read
cpu_addr  in  AW  cpu address
cpu_wdata  in  DW  cpu write data
cpu_gnt  out  1  request accepted this cycle
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid while cpu_done = 1, held until the next cpu read completes
cpu_stall  out  1  cpu_req & ~cpu_done (combinational)
host_req, host_wr, host_addr, host_wdata, host_gnt, host_done, host_rdata  same as cpu_* for the host port
dmem_addr  out  AW  memory address
dmem_data_out  out  DW  memory write data
dmem_wr  out  1  memory write strobe
dmem_data_in  in  DW  memory read data
busy  out  1  1 when state != IDLE

Behaviour:
- States: IDLE, WRITE, READ.
- Registers: owner, lat_addr, lat_wr, lat_wdata, cnt[1:0], last_owner, both rdata registers, both done registers.
- Reset (checked at a clock edge):
  - state=IDLE, last_owner=host (cpu wins the first tie), cnt=0.
  - All gnt/done=0, rdata=0, dmem_addr=0, dmem_data_out=0, dmem_wr=0, busy=0.
- Reset mid-access: the in-flight access is abandoned.
  - dmem_wr=0 from the cycle after the reset edge.
  - No done pulse is issued for the abandoned access.
- IDLE:
  - dmem_addr=0, dmem_data_out=0, dmem_wr=0.
  - Winner selection, combinational:
    - only one req high → that port wins;
    - both high, FIXED_PRIO=1 → cpu wins;
    - both high, FIXED_PRIO=0 → the port != last_owner wins.
  - gnt is asserted combinationally to the winner in the same cycle.
  - On that edge: latch addr/wr/wdata, owner=winner, last_owner=winner, cnt=0; go to WRITE if wr else READ.
- Requester rules:
  - req, addr, wr and wdata stay stable until gnt.
  - After gnt, inputs may change freely.
  - req still high after gnt is a new request, evaluated in the next IDLE cycle.
- WRITE (exactly 1 cycle):
  - dmem_addr=lat_addr, dmem_data_out=lat_wdata, dmem_wr=1.
  - Next state IDLE; owner's done=1 in the following cycle.
- READ (RD_LAT+1 cycles):
  - dmem_addr=lat_addr held, dmem_wr=0, dmem_data_out=0; cnt increments each cycle.
  - When cnt==RD_LAT: sample dmem_data_in into the owner's rdata and go to IDLE; owner's done=1 in the following cycle.
- Latency, gnt cycle = c0:
  - write: dmem_wr in c1, done in c2;
  - read: address c1..c(1+RD_LAT), done/rdata in c(2+RD_LAT).
- The done cycle is an IDLE cycle, so a new grant (either port) may occur in the same cycle as done. Back-to-back accesses have no dead cycle.
- done and gnt are never asserted to both ports in the same cycle.
- The non-owner's rdata is unaffected by the other port's accesses.
- Arithmetic: cnt is 2 bits, saturating never reached (RD_LAT ≤ 3); no address arithmetic is performed.

Test Plan:
- CPU write: cpu_req=1, wr=1, addr=0x0040, wdata=0xBEEF, held one cycle → cpu_gnt c0; c1 only: dmem_wr=1, dmem_addr=0x0040, dmem_data_out=0xBEEF; cpu_done c2; busy=1 c1 only.
- Host read, RD_LAT=1: host addr 0x0100, memory model returns 0x1234 one cycle after the address → dmem_addr=0x0100 in c1–c2; host_done=1 with host_rdata=0x1234 in c3; cpu_rdata stays 0.
- Contention after reset, FIXED_PRIO=0: both reqs held high, all writes → gnt order cpu, host, cpu, host; grants 2 cycles apart; each done coincides with the next gnt. With FIXED_PRIO=1 → cpu every grant, host_gnt never asserted.
- Stall: cpu read, RD_LAT=3 → cpu_stall=1 in c0–c4, cpu_done and cpu_stall=0 in c5 (cpu_stall drops to 0 exactly in the done cycle).
- Reset mid-read: reset asserted in c2 of a RD_LAT=2 read → from c3: busy=0, dmem_addr=0, no done. A new host write right after reset is granted immediately and completes normally.
- Stable rdata: cpu read returns 0xAAAA, then a host read returns 0x5555 → cpu_rdata remains 0xAAAA.
